vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator, the successor to the fixed 640x480 bar tester. It owns its own pixel-tick divider and sync counters. It produces four selectable patterns with programmable cell size and foreground/background colours, and drives the board's VGA DAC interface directly from the single system clock.

---
 rtl/vga_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: clk/2 pixel tick, sync counters, cell
// counters, four selectable patterns with per-frame shadowed mode and colours.
module vga_pattern_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CELL_W    = 32,
    parameter int CELL_H    = 24,
    parameter int COLOR_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   fg_color,
    input  logic [3*COLOR_W-1:0]   bg_color,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank,
    output logic                   vga_clock,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int CXW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CYW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int COLW    = (XW < 3) ? 3 : XW;
    localparam int RGB_W   = 3 * COLOR_W;

    logic              tick_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [CXW-1:0]    cx_r;
    logic [CYW-1:0]    cy_r;
    logic [COLW-1:0]   col_r;
    logic [YW-1:0]     row_r;
    logic [1:0]        mode_sh_r;
    logic [RGB_W-1:0]  fg_sh_r;
    logic [RGB_W-1:0]  bg_sh_r;

    logic              origin_s;
    logic              x_last_s;
    logic              y_last_s;
    logic              cx_last_s;
    logic              cy_last_s;
    logic              visible_s;
    logic              hsync_s;
    logic              vsync_s;
    logic [1:0]        eff_mode_s;
    logic [RGB_W-1:0]  eff_fg_s;
    logic [RGB_W-1:0]  eff_bg_s;
    logic [RGB_W-1:0]  pixel_s;
    logic [RGB_W-1:0]  rgb_next_s;

    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        return {{COLOR_W{idx[2]}}, {COLOR_W{idx[1]}}, {COLOR_W{idx[0]}}};
    endfunction

    assign origin_s  = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
    assign x_last_s  = (x_r == XW'(H_TOTAL - 1));
    assign y_last_s  = (y_r == YW'(V_TOTAL - 1));
    assign cx_last_s = (cx_r == CXW'(CELL_W - 1));
    assign cy_last_s = (cy_r == CYW'(CELL_H - 1));
    assign visible_s = (x_r < XW'(H_DISPLAY)) && (y_r < YW'(V_DISPLAY));
    assign hsync_s   = !((x_r >= XW'(H_DISPLAY + H_FRONT)) &&
                         (x_r <  XW'(H_DISPLAY + H_FRONT + H_SYNC)));
    assign vsync_s   = !((y_r >= YW'(V_DISPLAY + V_FRONT)) &&
                         (y_r <  YW'(V_DISPLAY + V_FRONT + V_SYNC)));

    // The shadow load and the first pixel share a tick, so (0,0) sees the live inputs.
    assign eff_mode_s = origin_s ? mode     : mode_sh_r;
    assign eff_fg_s   = origin_s ? fg_color : fg_sh_r;
    assign eff_bg_s   = origin_s ? bg_color : bg_sh_r;

    // Pattern colour for the current cell, forced to zero outside the visible area.
    always_comb begin
        pixel_s = {RGB_W{1'b0}};
        case (eff_mode_s)
            2'd0:    pixel_s = (col_r[0] ^ row_r[0]) ? eff_fg_s : eff_bg_s;
            2'd1:    pixel_s = col_r[0] ? eff_fg_s : eff_bg_s;
            2'd2:    pixel_s = row_r[0] ? eff_fg_s : eff_bg_s;
            2'd3:    pixel_s = bar_color(col_r[2:0]);
            default: pixel_s = {RGB_W{1'b0}};
        endcase
        rgb_next_s = visible_s ? pixel_s : {RGB_W{1'b0}};
    end

    // Pixel tick divider; doubles as the DAC pixel clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
        end
    end

    assign vga_clock = tick_r;

    // Raster position plus cell position, stepped together so no division is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r   <= {XW{1'b0}};
            y_r   <= {YW{1'b0}};
            cx_r  <= {CXW{1'b0}};
            cy_r  <= {CYW{1'b0}};
            col_r <= {COLW{1'b0}};
            row_r <= {YW{1'b0}};
        end else if (tick_r) begin
            if (x_last_s) begin
                x_r   <= {XW{1'b0}};
                cx_r  <= {CXW{1'b0}};
                col_r <= {COLW{1'b0}};
                if (y_last_s) begin
                    y_r   <= {YW{1'b0}};
                    cy_r  <= {CYW{1'b0}};
                    row_r <= {YW{1'b0}};
                end else begin
                    y_r <= y_r + YW'(1);
                    if (cy_last_s) begin
                        cy_r  <= {CYW{1'b0}};
                        row_r <= row_r + YW'(1);
                    end else begin
                        cy_r <= cy_r + CYW'(1);
                    end
                end
            end else begin
                x_r <= x_r + XW'(1);
                if (cx_last_s) begin
                    cx_r  <= {CXW{1'b0}};
                    col_r <= col_r + COLW'(1);
                end else begin
                    cx_r <= cx_r + CXW'(1);
                end
            end
        end
    end

    // Per-frame shadows of the pattern controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sh_r <= 2'd0;
            fg_sh_r   <= {RGB_W{1'b0}};
            bg_sh_r   <= {RGB_W{1'b0}};
        end else if (tick_r && origin_s) begin
            mode_sh_r <= mode;
            fg_sh_r   <= fg_color;
            bg_sh_r   <= bg_color;
        end
    end

    // Output registers; frame_start is cleared on the off-tick so it lasts one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            rgb         <= {RGB_W{1'b0}};
            frame_start <= 1'b0;
        end else if (tick_r) begin
            hsync       <= hsync_s;
            vsync       <= vsync_s;
            blank       <= visible_s;
            rgb         <= rgb_next_s;
            frame_start <= origin_s;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: a reduced-height main build plus a
// tiny build, both checked against an arithmetic raster/pattern model.
module tb_vga_pattern_gen;

    localparam int HD = 288, HF = 4, HS = 8, HB = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VD = 25, VF = 1, VS = 2, VB = 1;
    localparam int VT = VD + VF + VS + VB;
    localparam int CW = 32, CH = 24;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam int SHD = 16, SHT = 22, SVD = 8, SVT = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] fg_color = 24'h0;
    logic [23:0] bg_color = 24'h0;
    logic        hsync, vsync, blank, vga_clock, frame_start;
    logic [23:0] rgb;

    logic        sm_reset = 1'b1;
    logic [1:0]  sm_mode = 2'd0;
    logic [23:0] sm_fg = 24'h0;
    logic [23:0] sm_bg = 24'h0;
    logic        sm_hsync, sm_vsync, sm_blank, sm_vga_clock, sm_frame_start;
    logic [23:0] sm_rgb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [27:0] cap_out [HT*VT];
    bit          cap_fs  [HT*VT];
    bit          cap_ok  [HT*VT];
    int          cap_n = 0;
    logic [1:0]  cap_mode;
    logic [23:0] cap_fg, cap_bg;
    int          cap_cyc = 0, prev_cyc = 0;
    logic [23:0] fg1, bg1;

    vga_pattern_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CELL_W(CW), .CELL_H(CH), .COLOR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
        .hsync(hsync), .vsync(vsync), .blank(blank), .vga_clock(vga_clock),
        .rgb(rgb), .frame_start(frame_start)
    );

    vga_pattern_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .CELL_W(1), .CELL_H(1), .COLOR_W(8)
    ) dut_small (
        .clk(clk), .reset(sm_reset), .mode(sm_mode), .fg_color(sm_fg), .bg_color(sm_bg),
        .hsync(sm_hsync), .vsync(sm_vsync), .blank(sm_blank), .vga_clock(sm_vga_clock),
        .rgb(sm_rgb), .frame_start(sm_frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected {vga_clock, hsync, vsync, blank, rgb} for raster position (x,y) at a tick sample.
    function automatic logic [27:0] model_out(int x, int y, logic [1:0] m,
                                              logic [23:0] fg, logic [23:0] bg);
        bit vis, hs, vs;
        int col, row, c;
        logic [23:0] px;
        vis = (x < HD) && (y < VD);
        hs  = !((x >= HD + HF) && (x < HD + HF + HS));
        vs  = !((y >= VD + VF) && (y < VD + VF + VS));
        col = x / CW;
        row = y / CH;
        c   = col % 8;
        case (m)
            2'd0:    px = (((col + row) % 2) == 1) ? fg : bg;
            2'd1:    px = ((col % 2) == 1) ? fg : bg;
            2'd2:    px = ((row % 2) == 1) ? fg : bg;
            default: px = {(c >= 4) ? 8'hFF : 8'h00, ((c % 4) >= 2) ? 8'hFF : 8'h00,
                           ((c % 2) == 1) ? 8'hFF : 8'h00};
        endcase
        if (!vis) px = 24'h0;
        return {1'b0, hs, vs, vis, px};
    endfunction

    function automatic int frame_mismatches(output int first);
        int bad = 0;
        first = -1;
        for (int k = 0; k < cap_n; k++) begin
            if (cap_out[k] !== model_out(k % HT, k / HT, cap_mode, cap_fg, cap_bg) ||
                cap_fs[k] !== (k == 0) || !cap_ok[k]) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        return bad;
    endfunction

    // Records n_pix ticks from the next frame_start; drives input changes along the way.
    task automatic capture_frame(input int n_pix, input int sw_line, input logic [1:0] nm,
                                 input logic [23:0] nfg, input logic [23:0] nbg, input bit junk);
        int t = 0;
        while (frame_start !== 1'b1 && t < FRAME_CLK + 8) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_wait: got %b after %0d clk, want 1", frame_start, t);
        end
        prev_cyc = cap_cyc;
        cap_cyc  = cyc;
        cap_mode = mode; cap_fg = fg_color; cap_bg = bg_color; cap_n = n_pix;
        for (int k = 0; k < n_pix; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            cap_out[k] = {vga_clock, hsync, vsync, blank, rgb};
            cap_fs[k]  = frame_start;
            if (junk && (k / HT) < sw_line && $urandom_range(0, 63) == 0) begin
                mode     = 2'($urandom_range(0, 3));
                fg_color = 24'($urandom);
                bg_color = 24'($urandom);
            end
            if ((k / HT) == sw_line && (k % HT) == 0) begin
                mode = nm; fg_color = nfg; bg_color = nbg;
            end
            @(posedge clk); #1;
            cap_ok[k] = ({hsync, vsync, blank, rgb} === cap_out[k][26:0]) &&
                        (vga_clock === 1'b1) && (frame_start === 1'b0);
        end
    endtask

    task automatic test_reset();
        int c = 0;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if ({vga_clock, hsync, vsync, blank, rgb, frame_start} !== {4'b0110, 24'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_values: got %b_%h_%b want 0110_000000_0",
                         {vga_clock, hsync, vsync, blank}, rgb, frame_start);
            end
        end
        mode = 2'd0; fg_color = 24'hFFFFFF; bg_color = 24'h000000;
        @(negedge clk) reset = 1'b0;
        do begin @(posedge clk); #1; c++; end while (frame_start !== 1'b1 && c < 10);
        checks++;
        if (c != 2) begin
            errors++;
            $display("FAIL first_frame_start: got %0d clk after release, want 2", c);
        end
    endtask

    task automatic test_checkerboard();
        int bad, first, fl, cnt;
        int sx [5] = '{0, 32, 31, 32, 0};
        int sy [5] = '{0, 24, 0, 0, 24};
        logic [23:0] sv [5] = '{24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
        fg1 = 24'($urandom) | 24'h000001;
        bg1 = ~fg1;
        capture_frame(HT * VT, VD + 1, 2'd1, fg1, bg1, 1'b1);
        bad = frame_mismatches(first);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL checker_frame: %0d bad, first (%0d,%0d) got %h want %h", bad,
                     first % HT, first / HT, cap_out[first],
                     model_out(first % HT, first / HT, cap_mode, cap_fg, cap_bg));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_out[sy[i] * HT + sx[i]][23:0] !== sv[i]) begin
                errors++;
                $display("FAIL checker_pixel (%0d,%0d): got %h want %h", sx[i], sy[i],
                         cap_out[sy[i] * HT + sx[i]][23:0], sv[i]);
            end
        end
        cnt = 0;
        for (int k = 0; k < HT * VT; k++)
            if ((k % HT) >= HD && (cap_out[k][24] !== 1'b0 || cap_out[k][23:0] !== 24'h0)) cnt++;
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL hblank_region: got %0d lit pixels, want 0", cnt);
        end
        fl = -1; cnt = 0;
        for (int x = 0; x < HT; x++)
            if (cap_out[x][26] === 1'b0) begin
                if (fl < 0) fl = x;
                cnt++;
            end
        checks++;
        if (2 * fl != 2 * (HD + HF)) begin
            errors++;
            $display("FAIL hsync_fall: got %0d clk, want %0d", 2 * fl, 2 * (HD + HF));
        end
        checks++;
        if (2 * cnt != 2 * HS) begin
            errors++;
            $display("FAIL hsync_width: got %0d clk, want %0d", 2 * cnt, 2 * HS);
        end
        cnt = 0;
        for (int k = 0; k < HT * VT; k++) if (cap_out[k][25] === 1'b0) cnt++;
        checks++;
        if (2 * cnt != 2 * VS * HT) begin
            errors++;
            $display("FAIL vsync_width: got %0d clk, want %0d", 2 * cnt, 2 * VS * HT);
        end
    endtask

    task automatic test_mid_frame();
        int bad, first;
        capture_frame(HT * VT, 10, 2'd2, fg1, bg1, 1'b0);
        checks++;
        if (cap_cyc - prev_cyc != FRAME_CLK) begin
            errors++;
            $display("FAIL frame_period: got %0d clk, want %0d", cap_cyc - prev_cyc, FRAME_CLK);
        end
        bad = frame_mismatches(first);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vbars_frame: %0d bad, first (%0d,%0d) got %h", bad,
                     first % HT, first / HT, cap_out[first]);
        end
        checks++;
        if (cap_out[20 * HT + 32][23:0] !== fg1 || cap_out[20 * HT][23:0] !== bg1) begin
            errors++;
            $display("FAIL vbars_after_switch: got %h/%h want %h/%h",
                     cap_out[20 * HT + 32][23:0], cap_out[20 * HT][23:0], fg1, bg1);
        end
        capture_frame(HT * VT, 5, 2'd3, 24'($urandom), 24'($urandom), 1'b1);
        bad = frame_mismatches(first);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hbars_frame: %0d bad, first (%0d,%0d) got %h", bad,
                     first % HT, first / HT, cap_out[first]);
        end
        checks++;
        if (cap_out[40][23:0] !== bg1 || cap_out[24 * HT][23:0] !== fg1) begin
            errors++;
            $display("FAIL hbars_rows: got %h/%h want %h/%h",
                     cap_out[40][23:0], cap_out[24 * HT][23:0], bg1, fg1);
        end
    endtask

    task automatic test_colour_bars();
        int bad, first;
        int sx [9] = '{0, 31, 32, 63, 128, 159, 224, 255, 256};
        logic [23:0] sv [9] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF, 24'hFF0000,
                                24'hFF0000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        capture_frame(HT, -1, 2'd0, 24'h0, 24'h0, 1'b0);
        checks++;
        if (cap_cyc - prev_cyc != FRAME_CLK) begin
            errors++;
            $display("FAIL frame_period2: got %0d clk, want %0d", cap_cyc - prev_cyc, FRAME_CLK);
        end
        bad = frame_mismatches(first);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cbars_line: %0d bad, first x=%0d got %h", bad, first, cap_out[first]);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (cap_out[sx[i]][23:0] !== sv[i]) begin
                errors++;
                $display("FAIL cbars_pixel %0d: got %h want %h", sx[i], cap_out[sx[i]][23:0], sv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p = 3 * HT + 200;
        int c = 0;
        int bad, first;
        logic [27:0] e;
        for (int k = HT; k <= p; k++) begin
            @(posedge clk); #1;
            if (k < p) begin @(posedge clk); #1; end
        end
        e = model_out(200, 3, cap_mode, cap_fg, cap_bg);
        checks++;
        if ({hsync, vsync, blank, rgb} !== e[26:0]) begin
            errors++;
            $display("FAIL pre_reset_pixel: got %h want %h", {hsync, vsync, blank, rgb}, e[26:0]);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({vga_clock, hsync, vsync, blank, rgb, frame_start} !== {4'b0110, 24'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %b_%h_%b want 0110_000000_0",
                     {vga_clock, hsync, vsync, blank}, rgb, frame_start);
        end
        repeat (3) @(posedge clk);
        mode = 2'($urandom_range(0, 3)); fg_color = 24'($urandom); bg_color = 24'($urandom);
        @(negedge clk) reset = 1'b0;
        do begin @(posedge clk); #1; c++; end while (frame_start !== 1'b1 && c < 10);
        checks++;
        if (c != 2) begin
            errors++;
            $display("FAIL restart_frame_start: got %0d clk, want 2", c);
        end
        capture_frame(HT, -1, 2'd0, 24'h0, 24'h0, 1'b0);
        bad = frame_mismatches(first);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_line: %0d bad, first x=%0d got %h", bad, first, cap_out[first]);
        end
    endtask

    task automatic test_small_build();
        int t = 0, t0, bad = 0, first = -1, x, y;
        bit vis, hs, vs;
        logic [27:0] e;
        sm_fg = 24'($urandom) | 24'h000001;
        sm_bg = ~sm_fg;
        @(negedge clk) sm_reset = 1'b0;
        while (sm_frame_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        t0 = cyc;
        for (int k = 0; k < SHT * SVT; k++) begin
            if (k > 0) begin repeat (2) @(posedge clk); #1; end
            x = k % SHT; y = k / SHT;
            vis = (x < SHD) && (y < SVD);
            hs = !(x >= 18 && x < 20);
            vs = !(y >= 10 && y < 12);
            e = {1'b0, hs, vs, vis, vis ? ((((x + y) % 2) == 1) ? sm_fg : sm_bg) : 24'h0};
            if ({sm_vga_clock, sm_hsync, sm_vsync, sm_blank, sm_rgb} !== e ||
                sm_frame_start !== (k == 0)) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL small_checker: %0d bad, first (%0d,%0d)", bad, first % SHT, first / SHT);
        end
        t = 0;
        do begin @(posedge clk); #1; t++; end while (sm_frame_start !== 1'b1 && t < 1300);
        checks++;
        if (cyc - t0 != 2 * SHT * SVT) begin
            errors++;
            $display("FAIL small_period: got %0d clk, want %0d", cyc - t0, 2 * SHT * SVT);
        end
    endtask

    initial begin
        test_reset();
        test_checkerboard();
        test_mid_frame();
        test_colour_bars();
        test_reset_mid_frame();
        test_small_build();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
